// File: rtl/udc_pkg.sv
// Shared definitions for the up_down_counter target-seeking sequencer.
//   - FSM state encoding (S_IDLE, S_SEEK, S_DONE, S_ERR)
//   - default counter width
//   - direction encoding used by the direction selector
package udc_pkg;

   localparam int unsigned UDC_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEEK = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage : udc_pkg

// File: rtl/udc_dir_sel.sv
// Combinational direction selector for the counter sequencer.
// Ports:
//   count_in  [WIDTH]  current counter value
//   target    [WIDTH]  captured target value
//   need_step [1]      counter has not yet reached target
//   dir_up    [1]      DIR_UP to increment, DIR_DOWN to decrement
module udc_dir_sel
   import udc_pkg::*;
#(
   parameter int unsigned WIDTH    = UDC_WIDTH_DEF,
   parameter int unsigned SHORTEST = 1
)(
   input  logic [WIDTH-1:0] count_in,
   input  logic [WIDTH-1:0] target,
   output logic             need_step,
   output logic             dir_up
);

   // Half the modular range; a distance equal to it resolves towards up.
   localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] w_dist_up;

   assign w_dist_up = target - count_in;
   assign need_step = (count_in != target);

   generate
      if (SHORTEST != 0) begin : g_shortest
         assign dir_up = (w_dist_up <= HALF) ? DIR_UP : DIR_DOWN;
      end else begin : g_linear
         assign dir_up = (target > count_in) ? DIR_UP : DIR_DOWN;
      end
   endgenerate

endmodule : udc_dir_sel

// File: rtl/up_down_counter_seq.sv
// Target-seeking sequencer: accepts a target over valid/ready and strobes the
// attached up_down_counter one step per clock until count_in equals the target.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_target [WIDTH]    target count, captured on accept
//   cmd_abort             cancels an in-progress seek
//   count_in   [WIDTH]    registered counter output
//   up, down              combinational counter strobes
//   busy                  seek in progress
//   done, err             one-cycle completion / step-budget-exhausted pulses
//   steps      [WIDTH+2]  strobes issued by the current/last command
module up_down_counter_seq
   import udc_pkg::*;
#(
   parameter int unsigned WIDTH     = UDC_WIDTH_DEF,
   parameter int unsigned SHORTEST  = 1,
   parameter int unsigned MAX_STEPS = 20
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [WIDTH-1:0]   cmd_target,
   input  logic               cmd_abort,
   input  logic [WIDTH-1:0]   count_in,
   output logic               up,
   output logic               down,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [WIDTH+1:0]   steps
);

   localparam int unsigned    SW       = WIDTH + 2;
   localparam logic [SW-1:0]  STEP_MAX = SW'(MAX_STEPS);
   localparam logic [SW-1:0]  STEP_SAT = '1;

   state_t            r_state;
   state_t            w_next;
   logic [WIDTH-1:0]  r_target;
   logic [SW-1:0]     r_steps;
   logic              r_ready;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              w_need_step;
   logic              w_dir_up;
   logic              w_accept;
   logic              w_budget_ok;
   logic              w_step;

   udc_dir_sel #(
      .WIDTH    (WIDTH),
      .SHORTEST (SHORTEST)
   ) u_dir_sel (
      .count_in  (count_in),
      .target    (r_target),
      .need_step (w_need_step),
      .dir_up    (w_dir_up)
   );

   assign w_accept    = cmd_valid && r_ready;
   assign w_budget_ok = (r_steps < STEP_MAX);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; abort wins over arrival so an aborted seek never reports done
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_SEEK;
         end
         S_SEEK: begin
            if (cmd_abort)         w_next = S_IDLE;
            else if (!w_need_step) w_next = S_DONE;
            else if (!w_budget_ok) w_next = S_ERR;
         end
         S_DONE:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Combinational strobes; abort drops them in the same cycle
   always_comb begin
      w_step = 1'b0;
      up     = 1'b0;
      down   = 1'b0;
      if (r_state == S_SEEK && w_need_step && !cmd_abort && w_budget_ok) begin
         w_step = 1'b1;
         up     = (w_dir_up == DIR_UP);
         down   = (w_dir_up == DIR_DOWN);
      end
   end

   // Registered status outputs, decoded from the next state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ready <= (w_next == S_IDLE);
         r_busy  <= (w_next == S_SEEK);
         r_done  <= (w_next == S_DONE);
         r_err   <= (w_next == S_ERR);
      end
   end

   // Target capture and saturating step counter (held until the next accept)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_target <= '0;
         r_steps  <= '0;
      end else if (w_accept) begin
         r_target <= cmd_target;
         r_steps  <= '0;
      end else if (w_step && r_steps != STEP_SAT) begin
         r_steps  <= r_steps + SW'(1);
      end
   end

   assign cmd_ready = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign steps     = r_steps;

endmodule : up_down_counter_seq
